// File: rtl/ycr_pm_pkg.sv
// ---------------------------------------------------------------------------
// ycr_pm_pkg
// Shared power-management definitions for the sleep controller:
//   - pm_state_e     : controller state encoding (RUN, DRAIN, SLEEP, WAKE)
//   - CAUSE_*        : wake_cause codes reported to software
//   - wake_cause_enc : maps the wake sources active in one cycle to a code
// ---------------------------------------------------------------------------
package ycr_pm_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_SLEEP = 2'b10,
    ST_WAKE  = 2'b11
  } pm_state_e;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_TMR  = 2'b01;
  localparam logic [1:0] CAUSE_EXT  = 2'b10;
  localparam logic [1:0] CAUSE_BOTH = 2'b11;

  // Record every wake source that was active in the wake cycle.
  function automatic logic [1:0] wake_cause_enc(input logic tmr_hit, input logic ext_hit);
    logic [1:0] cause;
    case ({ext_hit, tmr_hit})
      2'b01:   cause = CAUSE_TMR;
      2'b10:   cause = CAUSE_EXT;
      2'b11:   cause = CAUSE_BOTH;
      default: cause = CAUSE_NONE;
    endcase
    return cause;
  endfunction

endpackage

// File: rtl/ycr_ost_cnt.sv
// ---------------------------------------------------------------------------
// ycr_ost_cnt
// Outstanding bus-transaction counter. Counts up on inc alone, down on dec
// alone, holds when both or neither are set. Saturates at all-ones; a
// decrement at zero holds zero and sets a sticky underflow error.
// Ports:
//   clk_in  - free-running clock
//   reset   - synchronous active-high reset
//   inc     - transaction issued
//   dec     - transaction completed
//   count   - current outstanding count (registered)
//   err     - sticky underflow error (registered)
// ---------------------------------------------------------------------------
module ycr_ost_cnt #(
  parameter int OST_W = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [OST_W-1:0] count,
  output logic             err
);

  logic [OST_W-1:0] count_r;
  logic             err_r;

  // Saturating up/down counter with sticky underflow flag.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      count_r <= '0;
      err_r   <= 1'b0;
    end else if (inc && !dec) begin
      if (count_r != '1) begin
        count_r <= count_r + OST_W'(1);
      end
    end else if (dec && !inc) begin
      if (count_r != '0) begin
        count_r <= count_r - OST_W'(1);
      end else begin
        err_r <= 1'b1;
      end
    end
  end

  assign count = count_r;
  assign err   = err_r;

endmodule

// File: rtl/ycr_sleep_ctrl.sv
// ---------------------------------------------------------------------------
// ycr_sleep_ctrl
// Core sleep controller. A software sleep request drains outstanding bus
// traffic, then parks the core in SLEEP (dst_idle high) until the wake timer
// expires or an external wake arrives, then raises a fixed-length wake IRQ.
// A drain that never completes is abandoned after DRN_TO cycles.
// Ports:
//   clk_in, reset            - free-running clock, synchronous active-high reset
//   slp_req                  - one-cycle sleep request (honoured only in RUN)
//   cfg_tmr_en, cfg_wake_tmr - timer wake enable and sleep duration
//   bus_req, bus_rsp         - bus transaction issue / completion strobes
//   ext_wake                 - synchronised external wake level
//   dst_idle                 - high exactly while in SLEEP
//   irq_wake                 - IRQ_STR-cycle wake pulse
//   wake_cause               - sources of the last wake (see ycr_pm_pkg)
//   slp_abort                - one-cycle pulse on drain timeout
//   ost_err                  - sticky response-without-request error
// ---------------------------------------------------------------------------
module ycr_sleep_ctrl
  import ycr_pm_pkg::*;
#(
  parameter int TMR_W   = 16,
  parameter int OST_W   = 4,
  parameter int IRQ_STR = 4,
  parameter int DRN_TO  = 255
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             slp_req,
  input  logic             cfg_tmr_en,
  input  logic [TMR_W-1:0] cfg_wake_tmr,
  input  logic             bus_req,
  input  logic             bus_rsp,
  input  logic             ext_wake,
  output logic             dst_idle,
  output logic             irq_wake,
  output logic [1:0]       wake_cause,
  output logic             slp_abort,
  output logic             ost_err
);

  localparam int               DRN_W    = $clog2(DRN_TO + 1);
  localparam logic [DRN_W-1:0] DRN_LIM  = DRN_W'(DRN_TO);
  localparam logic [3:0]       IRQ_LAST = 4'(IRQ_STR - 1);

  pm_state_e        state_r;
  logic [DRN_W-1:0] drn_cnt_r;
  logic [TMR_W-1:0] tmr_r;
  logic [3:0]       irq_cnt_r;
  logic             dst_idle_r;
  logic             irq_wake_r;
  logic [1:0]       wake_cause_r;
  logic             slp_abort_r;

  logic [OST_W-1:0] ost_cnt_s;
  logic             ost_err_s;
  logic [DRN_W-1:0] drn_inc_s;
  logic             tmr_exp_s;
  logic             wake_s;

  ycr_ost_cnt #(
    .OST_W (OST_W)
  ) u_ost_cnt (
    .clk_in (clk_in),
    .reset  (reset),
    .inc    (bus_req),
    .dec    (bus_rsp),
    .count  (ost_cnt_s),
    .err    (ost_err_s)
  );

  assign drn_inc_s = drn_cnt_r + DRN_W'(1);
  // A loaded value of 0 counts as already expired, so it wakes on the first
  // SLEEP cycle just like the value-1 case.
  assign tmr_exp_s = cfg_tmr_en && (tmr_r <= TMR_W'(1));
  assign wake_s    = tmr_exp_s || ext_wake;

  // Controller FSM with all outputs registered alongside the state.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_r      <= ST_RUN;
      drn_cnt_r    <= '0;
      tmr_r        <= '0;
      irq_cnt_r    <= 4'd0;
      dst_idle_r   <= 1'b0;
      irq_wake_r   <= 1'b0;
      wake_cause_r <= CAUSE_NONE;
      slp_abort_r  <= 1'b0;
    end else begin
      slp_abort_r <= 1'b0;
      case (state_r)
        ST_RUN: begin
          if (slp_req) begin
            state_r   <= ST_DRAIN;
            drn_cnt_r <= '0;
          end
        end
        ST_DRAIN: begin
          // Sleep wins over abort if both happen in the same cycle.
          if ((ost_cnt_s == '0) && !bus_req) begin
            state_r      <= ST_SLEEP;
            drn_cnt_r    <= '0;
            tmr_r        <= cfg_wake_tmr;
            wake_cause_r <= CAUSE_NONE;
            dst_idle_r   <= 1'b1;
          end else if (drn_inc_s == DRN_LIM) begin
            state_r     <= ST_RUN;
            drn_cnt_r   <= '0;
            slp_abort_r <= 1'b1;
          end else begin
            drn_cnt_r <= drn_inc_s;
          end
        end
        ST_SLEEP: begin
          if (cfg_tmr_en && (tmr_r != '0)) begin
            tmr_r <= tmr_r - TMR_W'(1);
          end
          if (wake_s) begin
            state_r      <= ST_WAKE;
            dst_idle_r   <= 1'b0;
            irq_wake_r   <= 1'b1;
            irq_cnt_r    <= 4'd0;
            wake_cause_r <= wake_cause_enc(tmr_exp_s, ext_wake);
          end
        end
        ST_WAKE: begin
          if (irq_cnt_r == IRQ_LAST) begin
            state_r    <= ST_RUN;
            irq_wake_r <= 1'b0;
          end else begin
            irq_cnt_r <= irq_cnt_r + 4'd1;
          end
        end
        default: begin
          state_r    <= ST_RUN;
          dst_idle_r <= 1'b0;
          irq_wake_r <= 1'b0;
        end
      endcase
    end
  end

  assign dst_idle   = dst_idle_r;
  assign irq_wake   = irq_wake_r;
  assign wake_cause = wake_cause_r;
  assign slp_abort  = slp_abort_r;
  assign ost_err    = ost_err_s;

endmodule

// File: tb/tb_ycr_sleep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ycr_sleep_ctrl
// Directed bench for ycr_sleep_ctrl with default parameters. Inputs are
// driven 1 time unit after each rising edge and outputs are sampled at the
// same point, so every check sees the state produced by the preceding edge.
// ---------------------------------------------------------------------------
module tb_ycr_sleep_ctrl;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        slp_req;
  logic        cfg_tmr_en;
  logic [15:0] cfg_wake_tmr;
  logic        bus_req;
  logic        bus_rsp;
  logic        ext_wake;
  logic        dst_idle;
  logic        irq_wake;
  logic [1:0]  wake_cause;
  logic        slp_abort;
  logic        ost_err;

  int checks = 0;
  int errors = 0;
  int abort_cnt = 0;
  int idle_cnt;
  int irq_cnt;
  int flag;

  ycr_sleep_ctrl dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .slp_req      (slp_req),
    .cfg_tmr_en   (cfg_tmr_en),
    .cfg_wake_tmr (cfg_wake_tmr),
    .bus_req      (bus_req),
    .bus_rsp      (bus_rsp),
    .ext_wake     (ext_wake),
    .dst_idle     (dst_idle),
    .irq_wake     (irq_wake),
    .wake_cause   (wake_cause),
    .slp_abort    (slp_abort),
    .ost_err      (ost_err)
  );

  always #5 clk_in = ~clk_in;

  // Count every abort pulse seen over the whole run.
  always @(negedge clk_in) begin
    if (slp_abort === 1'b1) abort_cnt++;
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; slp_req = 1'b0; cfg_tmr_en = 1'b1; cfg_wake_tmr = 16'd10;
    bus_req = 1'b0; bus_rsp = 1'b0; ext_wake = 1'b0;
    step(); step();
    chk("rst_idle",  32'(dst_idle),   32'd0);
    chk("rst_irq",   32'(irq_wake),   32'd0);
    chk("rst_cause", 32'(wake_cause), 32'd0);
    chk("rst_abort", 32'(slp_abort),  32'd0);
    chk("rst_err",   32'(ost_err),    32'd0);
    reset = 1'b0;
    step();

    // Timer wake, 10-cycle sleep.
    slp_req = 1'b1; step(); slp_req = 1'b0;
    chk("a_drain_idle", 32'(dst_idle), 32'd0);
    idle_cnt = 0; irq_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (dst_idle === 1'b1) idle_cnt++;
      if (irq_wake === 1'b1) irq_cnt++;
    end
    chk("a_idle_len", 32'(idle_cnt),   32'd10);
    chk("a_irq_len",  32'(irq_cnt),    32'd4);
    chk("a_cause",    32'(wake_cause), 32'd1);

    // Timer expiry and ext_wake in the same cycle.
    cfg_wake_tmr = 16'd3;
    slp_req = 1'b1; step(); slp_req = 1'b0;
    step();
    chk("b_idle",      32'(dst_idle),   32'd1);
    chk("b_cause_clr", 32'(wake_cause), 32'd0);
    step(); step();
    ext_wake = 1'b1; step(); ext_wake = 1'b0;
    chk("b_wake_idle", 32'(dst_idle),   32'd0);
    chk("b_cause",     32'(wake_cause), 32'd3);
    irq_cnt = (irq_wake === 1'b1) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (irq_wake === 1'b1) irq_cnt++;
    end
    chk("b_irq_len",    32'(irq_cnt),    32'd4);
    chk("b_cause_hold", 32'(wake_cause), 32'd3);

    // Timer disabled: frozen; bus_req in SLEEP must not wake; ext wake alone.
    cfg_tmr_en = 1'b0; cfg_wake_tmr = 16'd2;
    slp_req = 1'b1; step(); slp_req = 1'b0;
    step();
    bus_req = 1'b1; step(); bus_req = 1'b0;
    step(); step(); step(); step();
    chk("c_frozen_idle", 32'(dst_idle), 32'd1);
    ext_wake = 1'b1; step(); ext_wake = 1'b0;
    chk("c_irq",   32'(irq_wake),   32'd1);
    chk("c_cause", 32'(wake_cause), 32'd2);
    step(); step(); step(); step();
    bus_rsp = 1'b1; step(); bus_rsp = 1'b0;
    chk("c_err", 32'(ost_err), 32'd0);

    // Zero wake time wakes on the first SLEEP cycle.
    cfg_tmr_en = 1'b1; cfg_wake_tmr = 16'd0;
    slp_req = 1'b1; step(); slp_req = 1'b0;
    step();
    chk("d_idle", 32'(dst_idle), 32'd1);
    step();
    chk("d_irq",   32'(irq_wake),   32'd1);
    chk("d_cause", 32'(wake_cause), 32'd1);
    step(); step(); step(); step();

    // Three outstanding requests drained by responses.
    cfg_wake_tmr = 16'd2;
    flag = abort_cnt;
    bus_req = 1'b1; step(); step(); step(); bus_req = 1'b0;
    slp_req = 1'b1; step(); slp_req = 1'b0;
    step(); step(); step(); step();
    chk("e_wait_idle", 32'(dst_idle), 32'd0);
    bus_rsp = 1'b1; step(); step(); step(); bus_rsp = 1'b0;
    chk("e_last_rsp_idle", 32'(dst_idle), 32'd0);
    step();
    chk("e_sleep", 32'(dst_idle), 32'd1);
    for (int i = 0; i < 10; i++) step();
    chk("e_no_abort", 32'(abort_cnt - flag), 32'd0);

    // Saturation: 17 requests saturate at 15, 15 responses empty it.
    bus_req = 1'b1; for (int i = 0; i < 17; i++) step(); bus_req = 1'b0;
    bus_rsp = 1'b1; for (int i = 0; i < 15; i++) step(); bus_rsp = 1'b0;
    slp_req = 1'b1; step(); slp_req = 1'b0;
    step();
    chk("f_sat_sleep", 32'(dst_idle), 32'd1);
    chk("f_sat_err",   32'(ost_err),  32'd0);
    for (int i = 0; i < 10; i++) step();

    // One request never answered: drain timeout after 255 cycles.
    bus_req = 1'b1; step(); bus_req = 1'b0;
    slp_req = 1'b1; step(); slp_req = 1'b0;
    flag = 0;
    for (int i = 1; i < 255; i++) begin
      step();
      if (slp_abort === 1'b1 || dst_idle === 1'b1) flag = 1;
    end
    chk("g_quiet", 32'(flag), 32'd0);
    step();
    chk("g_abort", 32'(slp_abort), 32'd1);
    step();
    chk("g_abort_pulse", 32'(slp_abort), 32'd0);
    chk("g_no_idle",     32'(dst_idle),  32'd0);
    bus_rsp = 1'b1; step(); bus_rsp = 1'b0;
    slp_req = 1'b1; step(); slp_req = 1'b0;
    step();
    chk("g_back_in_run", 32'(dst_idle), 32'd1);
    for (int i = 0; i < 10; i++) step();

    // Response with nothing outstanding.
    bus_rsp = 1'b1; step(); bus_rsp = 1'b0;
    chk("h_err", 32'(ost_err), 32'd1);
    step(); step();
    chk("h_err_sticky", 32'(ost_err), 32'd1);
    slp_req = 1'b1; step(); slp_req = 1'b0;
    step();
    chk("h_count_zero", 32'(dst_idle), 32'd1);
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("h_err_rst", 32'(ost_err), 32'd0);

    // Reset on the third SLEEP cycle.
    cfg_wake_tmr = 16'd10;
    slp_req = 1'b1; step(); slp_req = 1'b0;
    step(); step(); step();
    chk("i_pre_idle", 32'(dst_idle), 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("i_idle", 32'(dst_idle), 32'd0);
    chk("i_irq",  32'(irq_wake), 32'd0);
    flag = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (irq_wake === 1'b1 || dst_idle === 1'b1) flag = 1;
    end
    chk("i_no_wake", 32'(flag), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
